lane_rr_scheduler: RTL
======================

// Module: lane_rr_scheduler
// PURPOSE
//  - Shares one DATA_W-bit output bus among 4 requesting lanes.
//  - Round-robin arbitration with bounded bursts; sits between the per-lane sources and the serializer.
//  - Also emits the phase strobes en4f/en2f/enf, so downstream logic runs from clk8f alone.
//  - The phase strobes replace the divided clocks clk4f/clk2f/clkf.
// PARAMETERS
//  DATA_W     8      width of each lane payload and of data_out
//  MAX_BURST  4      max consecutive transfers granted to one lane (1..15)
//  IDLE_SYM   8'hBC  value driven on data_out whenever valid_out=0
// PORTS
//  clk8f      in   1         single clock; all logic on posedge
//  reset      in   1         synchronous, active-low: reset==0 at posedge resets the block
//  req_valid  in   4         lane i holds a word on data_in<i>
//  data_in0   in   DATA_W    lane 0 payload (data_in1..data_in3 identical, lanes 1..3)
//  req_ready  out  4         one-hot or zero; lane i word accepted when req_valid[i]&req_ready[i]
//  out_ready  in   1         downstream can accept a word this cycle
//  data_out   out  DATA_W    registered granted word, IDLE_SYM when idle
//  valid_out  out  1         data_out holds a real word
//  lane_id    out  2         source lane of data_out (0 when idle)
//  en4f       out  1         high on cnt[0]==1 (every 2nd cycle)
//  en2f       out  1         high on cnt[1:0]==3 (every 4th cycle)
//  enf        out  1         high on cnt==7 (every 8th cycle)
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - cnt=0; state=IDLE; ptr=3, so lane 0 is checked first.
//    - burst_cnt=0; data_out=IDLE_SYM; valid_out=0; lane_id=0.
//    - en4f, en2f and enf are all 0.
//  - Reset mid-burst wins over everything; any in-flight word is dropped.
//  - cnt: free-running 3-bit counter, wraps 7->0.
//    - The strobes are registered decodes of the next count, so they align with cnt.
//    - First en4f pulse: 2nd cycle after reset release; first enf: 8th cycle.
//  - Accept condition: req_ready is all-zero when out_ready==0 or while reset is asserted.
//  - Winner search: first lane with req_valid=1, scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
//  - FSM states:
//    - IDLE: no owner.
//      - On winner w: req_ready[w]=1 (combinational); on transfer go to OWN(w), burst_cnt=1.
//    - OWN(o): req_ready[o]=1 when req_valid[o] and burst_cnt<MAX_BURST.
//      - Transfer: burst_cnt++.
//    - Leaving OWN(o): triggered by req_valid[o]==0 or burst_cnt==MAX_BURST.
//      - ptr=o; re-arbitrate in the same cycle, excluding nothing.
//      - If o is the only requester it may win again, with burst_cnt restarting at 1.
//      - If there is no winner, go to IDLE.
//  - Fairness: with all 4 lanes valid, grant order is lane 0 x MAX_BURST, 1, 2, 3, 0, ...
//    - Zero bubble cycles between bursts.
//  - Datapath latency: 1 cycle.
//    - Transfer at edge k gives data_out=data_in<i>, lane_id=i, valid_out=1 after edge k.
//    - out_ready==1 with no transfer gives valid_out=0, data_out=IDLE_SYM, lane_id=0.
//    - out_ready==0 holds data_out/valid_out/lane_id unchanged; the FSM, burst_cnt and ptr also hold.
//  - Backpressure: a lane dropping req_valid while ready is 0 is legal; the word is never taken.
//  - burst_cnt: 4 bits; never exceeds MAX_BURST.
// TESTING
//  - Reset: reset=0 for 3 cycles with all req_valid=1.
//    -> req_ready=0, valid_out=0, data_out=8'hBC, en*=0.
//    -> First enf exactly 8 cycles after release.
//  - Single lane: req_valid=4'b0100, data_in2=8'h11..8'h16.
//    -> 6 words out in order, lane_id=2, 1-cycle latency.
//    -> With MAX_BURST=4, ready drops for 0 cycles: the lane re-wins.
//  - Full contention: req_valid=4'b1111, MAX_BURST=4.
//    -> Lane order 0,0,0,0,1,1,1,1,2..3..,0 with valid_out continuously 1.
//  - Backpressure: out_ready=0 for 5 cycles mid-burst.
//    -> req_ready=0 and outputs frozen.
//    -> Burst resumes with burst_cnt unchanged and no word lost or duplicated.
//  - Early release: lane 1 owns and drops req_valid after 2 words while lane 3 waits.
//    -> Lane 3 granted the next cycle; idle output 8'hBC never appears.
//  - Mid-burst reset: reset=0 during OWN(2).
//    -> Next cycle all outputs at reset values; after release lane 0 is checked first.

Source files
------------

// File: rtl/lane_rr_scheduler.sv
// Four-lane round-robin scheduler with bounded bursts onto one output bus.
// Also generates the en4f/en2f/enf phase strobes from the clk8f counter.
//
// Ports:
//   clk8f      single clock, all logic on posedge
//   reset      synchronous, active-low
//   req_valid  per-lane word present on data_in0..3
//   data_in0-3 per-lane payloads
//   req_ready  one-hot (or zero) accept strobe back to the lanes
//   out_ready  downstream can take a word this cycle
//   data_out   registered granted word, IDLE_SYM when idle
//   valid_out  data_out holds a real word
//   lane_id    source lane of data_out (0 when idle)
//   en4f       phase strobe, high when cnt[0]==1
//   en2f       phase strobe, high when cnt[1:0]==3
//   enf        phase strobe, high when cnt==7
module lane_rr_scheduler #(
   parameter int                DATA_W    = 8,
   parameter int                MAX_BURST = 4,
   parameter logic [DATA_W-1:0] IDLE_SYM  = 8'hBC
) (
   input  logic              clk8f,
   input  logic              reset,
   input  logic [3:0]        req_valid,
   input  logic [DATA_W-1:0] data_in0,
   input  logic [DATA_W-1:0] data_in1,
   input  logic [DATA_W-1:0] data_in2,
   input  logic [DATA_W-1:0] data_in3,
   output logic [3:0]        req_ready,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [1:0]        lane_id,
   output logic              en4f,
   output logic              en2f,
   output logic              enf
);

   typedef enum logic {
      IDLE,
      OWN
   } state_t;

   localparam logic [3:0] MAXB = 4'(MAX_BURST);

   state_t      state_q, state_d;
   logic [1:0]  owner_q, owner_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [3:0]  burst_q, burst_d;
   logic [2:0]  cnt_q, cnt_nxt;

   logic [DATA_W-1:0] din [4];

   logic       hold;
   logic       found;
   logic [1:0] base;
   logic [1:0] cand;
   logic [1:0] win;
   logic       xfer;
   logic [1:0] gnt_lane;

   assign din[0] = data_in0;
   assign din[1] = data_in1;
   assign din[2] = data_in2;
   assign din[3] = data_in3;

   assign cnt_nxt = cnt_q + 3'd1;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      ptr_d    = ptr_q;
      burst_d  = burst_q;
      xfer     = 1'b0;
      gnt_lane = 2'd0;
      found    = 1'b0;
      win      = 2'd0;
      cand     = 2'd0;

      // Owner keeps the bus while it still has words and burst room.
      hold = (state_q == OWN) && req_valid[owner_q]
             && (burst_q < MAXB);

      // Leaving an owner re-arbitrates from that owner in the same cycle.
      base = (state_q == OWN) ? owner_q : ptr_q;

      // Scan base+1 .. base+4; the last step wraps back to base itself.
      for (int k = 1; k <= 4; k++) begin
         cand = base + 2'(k);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end

      if (reset && out_ready) begin
         if (hold) begin
            xfer     = 1'b1;
            gnt_lane = owner_q;
            burst_d  = burst_q + 4'd1;
         end else begin
            if (state_q == OWN) begin
               ptr_d = owner_q;
            end
            if (found) begin
               xfer     = 1'b1;
               gnt_lane = win;
               state_d  = OWN;
               owner_d  = win;
               burst_d  = 4'd1;
            end else begin
               state_d  = IDLE;
               burst_d  = 4'd0;
            end
         end
      end

      req_ready = xfer ? (4'b0001 << gnt_lane) : 4'b0000;
   end

   always_ff @(posedge clk8f) begin
      if (!reset) begin
         cnt_q     <= 3'd0;
         en4f      <= 1'b0;
         en2f      <= 1'b0;
         enf       <= 1'b0;
         state_q   <= IDLE;
         owner_q   <= 2'd0;
         ptr_q     <= 2'd3;
         burst_q   <= 4'd0;
         data_out  <= IDLE_SYM;
         valid_out <= 1'b0;
         lane_id   <= 2'd0;
      end else begin
         cnt_q   <= cnt_nxt;
         // Strobes decode the next count so they line up with cnt.
         en4f    <= cnt_nxt[0];
         en2f    <= &cnt_nxt[1:0];
         enf     <= &cnt_nxt;
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         burst_q <= burst_d;
         if (out_ready) begin
            valid_out <= xfer;
            data_out  <= xfer ? din[gnt_lane] : IDLE_SYM;
            lane_id   <= xfer ? gnt_lane : 2'd0;
         end
      end
   end

endmodule
